// File: rtl/serial_addsub_n.sv
// serial_addsub_n: LSB-first bit-serial inc/add/sub/dec of WIDTH-bit words.
// Ports: clk, reset (async, active-low), in_valid, start, mode[1:0], a_bit, b_bit
//        -> out_valid, sum_bit, last (combinational), cout, cout_valid (registered).
// Optional: define SERIAL_ADDSUB_OVF_EN to add the registered ovf output.
module serial_addsub_n #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       a_bit,
  input  logic       b_bit,
  output logic       out_valid,
  output logic       sum_bit,
  output logic       last,
  output logic       cout,
  output logic       cout_valid
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic       ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] M_INC = 2'b00;
  localparam logic [1:0] M_ADD = 2'b01;
  localparam logic [1:0] M_SUB = 2'b10;
  localparam logic [1:0] M_DEC = 2'b11;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [1:0]    mode_q;

  logic          acc;
  logic          is_last;
  logic [1:0]    eff_mode;
  logic          bp;
  logic          cin;
  logic          sum_raw;
  logic          c_next;

  // Reset gating keeps every output at 0 while reset is held low.
  assign acc = reset & in_valid & (start | (state == RUN));
  assign is_last = acc & ~start & (cnt == CNT_MAX);

  assign eff_mode = start ? mode : mode_q;

  always_comb begin
    bp  = 1'b0;
    cin = carry;
    unique case (eff_mode)
      M_INC: bp = 1'b0;
      M_ADD: bp = b_bit;
      M_SUB: bp = ~b_bit;
      M_DEC: bp = 1'b1;
      default: bp = 1'b0;
    endcase
    if (start) begin
      cin = (mode == M_INC) | (mode == M_SUB);
    end
  end

  assign sum_raw = a_bit ^ bp ^ cin;
  assign c_next  = (a_bit & bp) | (a_bit & cin) | (bp & cin);

  assign out_valid = acc;
  assign sum_bit   = acc & sum_raw;
  assign last      = is_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      carry      <= 1'b0;
      mode_q     <= M_INC;
      cout       <= 1'b0;
      cout_valid <= 1'b0;
    end else begin
      // A start beat during RUN simply restarts the frame: is_last
      // stays low, so the abandoned word never reports.
      cout_valid <= is_last;
      if (acc) begin
        carry <= c_next;
        if (start) begin
          mode_q <= mode;
          cnt    <= CNT_ONE;
          state  <= RUN;
        end else if (is_last) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
      if (is_last) begin
        cout <= c_next;
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  // Overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (is_last) begin
      ovf <= cin ^ c_next;
    end
  end
`endif

endmodule

// File: doc/serial_addsub_n.md
Name: serial_addsub_n

Overview:
- Parametrised bit-serial arithmetic unit and successor to the fixed 4-bit serial incrementer.
- Processes WIDTH-bit words arriving LSB-first, one bit per accepted cycle.
- Modes: increment, add, subtract, decrement.
- Supports input stalls, frame resync on start, and a registered end-of-word carry/borrow report.
- Sits between bit-serial shift registers in the sequential datapath.

Parameters:
- WIDTH, 4, word length in bits (>=2). Counter width is $clog2(WIDTH).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  a_bit/b_bit/start/mode valid this cycle
- start  in  1  marks LSB (bit 0) of a new word; qualified by in_valid
- mode  in  2  00 inc, 01 add, 10 sub (a-b), 11 dec; sampled only on the start beat
- a_bit  in  1  operand A serial bit
- b_bit  in  1  operand B serial bit; ignored in inc/dec
- out_valid  out  1  sum_bit valid (combinational, = accepted beat)
- sum_bit  out  1  result bit, same cycle as its input bit (Mealy)
- last  out  1  high with out_valid on bit WIDTH-1
- cout  out  1  registered final carry (add/inc) or no-borrow flag (sub/dec)
- cout_valid  out  1  one-cycle pulse, cycle after last

Behaviour:
- Single clock; reset is asynchronous and active-low.
- Reset values: state IDLE, bit count 0, carry 0, latched mode 00, cout 0, cout_valid 0. With reset low, all outputs are 0.
- States:
  - IDLE: waiting for a start beat.
  - RUN: inside a word, bit count 1..WIDTH-1.
- Beat = in_valid high in a cycle. Without in_valid: no state, count or carry change; out_valid=0, sum_bit=0, last=0.
- Operand b' and carry-in for bit 0, by mode:
  - inc: b'=0, cin=1.
  - add: b'=b_bit, cin=0.
  - sub: b'=~b_bit, cin=1.
  - dec: b'=1, cin=0.
- Start beat (IDLE or RUN):
  - Latch mode; compute with mode-derived cin.
  - sum_bit = a^b'^cin.
  - carry <= maj(a,b',cin); count <= 1; go to RUN.
- Non-start beat in RUN:
  - sum_bit = a^b'^carry; carry updated.
  - Count increments. On count==WIDTH-1: last=1, go to IDLE, count <= 0.
- Start beat while in RUN (resync): the current word is abandoned and no cout_valid is issued for it. The new word begins with this beat as bit 0.
- Non-start beat in IDLE: ignored; out_valid=0, no state change.
- Last beat: the cycle after last, cout_valid=1 for exactly one cycle, and cout holds the final carry-out until the next cout_valid. The next word may start in the same cycle cout_valid is high.
- WIDTH=2 edge: a start beat followed by one beat completes the word.
- Reset mid-word: immediate return to reset values; a partial word produces no cout_valid.

Optional Feature:
- Macro: SERIAL_ADDSUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered and valid with cout_valid.
  - ovf = carry into MSB XOR carry out of MSB, i.e. two's-complement overflow of the word.
  - Reset 0; holds like cout.
- Undefined: port absent; no extra logic.

Test Plan:
- WIDTH=4, mode inc, A=0111 (bits 1,1,1,0) -> sum bits 0,0,0,1 (1000); last on 4th beat; next cycle cout_valid=1, cout=0 (ovf=1 if enabled).
- inc A=1111 -> sum 0000, cout=1, ovf=0. Then mode dec A=0000 -> sum 1111, cout=0 (borrow).
- add A=0101, B=0011 with in_valid low for 2 cycles between beats 2 and 3 -> sum 1000 unchanged by stall; out_valid low during stall; cout=0, ovf=1.
- sub A=0011, B=0101 -> sum 1110, cout=0 (borrow). sub A=0101, B=0011 -> sum 0010, cout=1.
- Resync: start a word, give 2 beats, assert start again with add A=0001, B=0001 -> no cout_valid for the aborted word; new sum 0010, cout_valid exactly once.
- Drop reset during beat 3 of a word -> all outputs 0 immediately; no cout_valid after release. The first start beat after release processes normally.
